mult_pipe_hs: RTL and testbench

- Parametrised successor to the fixed 32x32 register-in/register-out multiplier wrapper.
- Multiplies operands of configurable width. Signedness is selected per transaction.
- Result pipeline has configurable depth and uses a valid/ready handshake with backpressure.
- Sits between operand producers and downstream consumers in the multiplier characterisation flow. It also serves as a drop-in multiply unit for datapath blocks.

---
 rtl/mult_pipe_hs.sv | 98 +++++++++
 tb/tb_mult_pipe_hs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_hs.sv
// Pipelined WIDTH_A x WIDTH_B multiplier with per-beat signedness and valid/ready backpressure.
// Optional sideband tag path enabled by defining MULT_PIPE_TAG_EN.
module mult_pipe_hs #(
  parameter int unsigned WIDTH_A = 32,
  parameter int unsigned WIDTH_B = 32,
  parameter int unsigned STAGES  = 3
`ifdef MULT_PIPE_TAG_EN
  , parameter int unsigned TAG_W = 4
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       is_signed,
  input  logic [WIDTH_A-1:0]         multiplicand,
  input  logic [WIDTH_B-1:0]         multiplier,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] product,
  output logic                       busy
`ifdef MULT_PIPE_TAG_EN
  , input  logic [TAG_W-1:0]         in_tag
  , output logic [TAG_W-1:0]         out_tag
`endif
);

  localparam int unsigned PW = WIDTH_A + WIDTH_B;

  logic               adv;
  logic [STAGES:1]    valid_q;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic               sgn_q;
  logic [PW-1:0]      ext_a;
  logic [PW-1:0]      ext_b;
  logic [PW-1:0]      mul_c;
  logic [PW-1:0]      prod_q [2:STAGES];

  // Whole pipeline moves together; it only freezes when the output holds an unaccepted product.
  assign adv       = !valid_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES];
  assign product   = prod_q[STAGES];
  assign busy      = |valid_q;

  // Extend both operands to the full product width, then a single PW x PW multiply truncated to PW.
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    if (sgn_q) begin
      ext_a = PW'($signed(a_q));
      ext_b = PW'($signed(b_q));
    end else begin
      ext_a = PW'(a_q);
      ext_b = PW'(b_q);
    end
    mul_c = ext_a * ext_b;
  end

  // Valid bits shift every advance (bubbles included); data only loads behind a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      prod_q[STAGES] <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[STAGES-1:1], in_valid};
      if (in_valid) begin
        a_q   <= multiplicand;
        b_q   <= multiplier;
        sgn_q <= is_signed;
      end
      if (valid_q[1]) prod_q[2] <= mul_c;
      for (int unsigned s = 3; s <= STAGES; s++) begin
        if (valid_q[s-1]) prod_q[s] <= prod_q[s-1];
      end
    end
  end

`ifdef MULT_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_q [1:STAGES];

  assign out_tag = tag_q[STAGES];

  // Tag rides alongside the beat with the same load and stall rules as the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 1; s <= STAGES; s++) tag_q[s] <= '0;
    end else if (adv) begin
      if (in_valid) tag_q[1] <= in_tag;
      for (int unsigned s = 2; s <= STAGES; s++) begin
        if (valid_q[s-1]) tag_q[s] <= tag_q[s-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Randomised and directed bench for mult_pipe_hs: a 32x32/3-stage instance with a scoreboard
// plus a 16x8/5-stage instance for mixed-width latency and corner checks.
module tb_mult_pipe_hs;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [31:0] multiplicand, multiplier;
  logic [63:0] product;
  logic [3:0]  in_tag, out_tag;

  logic        b_in_valid, b_in_ready, b_sgn, b_out_valid, b_busy;
  logic [15:0] b_a;
  logic [7:0]  b_b;
  logic [23:0] b_product;
  logic [3:0]  b_out_tag;

  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];
  logic stalled = 1'b0;
  logic [63:0] held;

  always #5 clk = ~clk;

  mult_pipe_hs #(.WIDTH_A(32), .WIDTH_B(32), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
`ifdef MULT_PIPE_TAG_EN
    , .in_tag(in_tag), .out_tag(out_tag)
`endif
  );

  mult_pipe_hs #(.WIDTH_A(16), .WIDTH_B(8), .STAGES(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .is_signed(b_sgn),
    .multiplicand(b_a), .multiplier(b_b), .out_valid(b_out_valid),
    .out_ready(1'b1), .product(b_product), .busy(b_busy)
`ifdef MULT_PIPE_TAG_EN
    , .in_tag(4'd0), .out_tag(b_out_tag)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference product: operands interpreted as integers, multiplied, reduced mod 2^(wa+wb).
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int wa, input int wb);
    longint va, vb;
    logic [63:0] r, mask;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[wa-1]) va = va - (longint'(1) << wa);
    if (s && b[wb-1]) vb = vb - (longint'(1) << wb);
    r = 64'(va * vb);
    mask = (wa + wb == 64) ? '1 : ((64'd1 << (wa + wb)) - 64'd1);
    return r & mask;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard for the 32x32 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(q.size() != 0));
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_prod", product, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check("prod", product, q[0].p);
`ifdef MULT_PIPE_TAG_EN
          check("tag", 64'(out_tag), 64'(q[0].t));
`endif
          void'(q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held = product;
      if (in_valid && in_ready)
        q.push_back('{ref_mul(64'(multiplicand), 64'(multiplier), is_signed, 32, 32), in_tag});
    end
  end

  task automatic run_one_a(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] expv);
    int n = 0;
    in_valid = 1'b1; multiplicand = a; multiplier = b; is_signed = s; out_ready = 1'b1;
    in_tag = 4'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("a_lat", 64'(n), 64'd2);
    check("a_prod", product, expv);
    @(posedge clk); #1;
  endtask

  task automatic run_one_b(input logic [15:0] a, input logic [7:0] b, input logic s,
                           input logic [63:0] expv);
    int n = 0;
    b_in_valid = 1'b1; b_a = a; b_b = b; b_sgn = s;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("b_lat", 64'(n), 64'd4);
    check("b_prod", 64'(b_product), expv);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    int n, cyc;
    pat = 4'b1001;
    rst = 1'b1; in_valid = 1'b1; is_signed = 1'b0; multiplicand = 32'd6; multiplier = 32'd7;
    out_ready = 1'b0; in_tag = 4'd0;
    b_in_valid = 1'b0; b_a = '0; b_b = '0; b_sgn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_b_busy", 64'(b_busy), 64'd0);
`ifdef MULT_PIPE_TAG_EN
    check("rst_tag", 64'(out_tag), 64'd0);
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Width-boundary corners with independently derived constants.
    run_one_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_one_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_one_a(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_one_a(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_one_a(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);

    // Back-to-back stream under a 1,0,0,1 out_ready pattern.
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      in_valid = 1'b1; multiplicand = rnd32(); multiplier = rnd32(); is_signed = 1'($urandom);
      in_tag = 4'(n); out_ready = pat[cyc % 4];
      #1;
      check("in_ready_adv", 64'(in_ready), 64'(!out_valid || out_ready));
      if (in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_all_accepted", 64'(n), 64'd8);
    drain();

    // Reset in flight: two accepted beats and one offered during reset must all vanish.
    out_ready = 1'b1; in_valid = 1'b1; is_signed = 1'b0;
    multiplicand = 32'd7; multiplier = 32'd9;
    @(posedge clk); #1;
    multiplicand = 32'd11; multiplier = 32'd13;
    @(posedge clk); #1;
    multiplicand = 32'd1; multiplier = 32'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_product", product, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("post_rst_idle", 64'(busy), 64'd0);
    run_one_a(32'd3, 32'd5, 1'b0, 64'd15);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); multiplicand = rnd32(); multiplier = rnd32();
      is_signed = 1'($urandom); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Mixed-width instance.
    run_one_b(16'h8000, 8'h7F, 1'b1, 64'hC0_8000);
    run_one_b(16'hFFFF, 8'hFF, 1'b0, 64'hFE_FF01);
    run_one_b(16'h8000, 8'h80, 1'b1, 64'h40_0000);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      logic        rs;
      ra = 16'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run_one_b(ra, rb, rs, ref_mul(64'(ra), 64'(rb), rs, 16, 8));
    end
    check("b_idle", 64'(b_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
